// File: rtl/byte_pack_stage_if.sv
// Byte-stream handshake bundle for byte_pack_stage: upstream bytes in, packed
// data/checksum bytes out. The slave modport is the packer's view.
interface byte_pack_stage_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_is_csum;
    logic       pkt_done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_is_csum, pkt_done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_is_csum, pkt_done
    );
endinterface

// File: rtl/byte_pack_stage.sv
// Buffers incoming bytes in a small FIFO and emits them in packets of PKT_LEN
// data bytes, each followed by a mod-256 checksum byte.
module byte_pack_stage #(
    parameter int PKT_LEN = 4,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rstn,
    byte_pack_stage_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    typedef enum logic {S_DATA, S_CSUM} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [7:0]      sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_is_csum_q, out_is_csum_d;
    logic            pkt_done_q, pkt_done_d;

    logic fifo_full, fifo_empty, push, pop, out_free, load_csum;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign fifo_full    = (occ_q == FULL_OCC);
    assign fifo_empty   = (occ_q == '0);
    // A pop never frees room for a same-cycle write: readiness looks only at occupancy.
    assign bus.in_ready = !fifo_full && rstn;
    assign push         = bus.in_valid && bus.in_ready;
    assign out_free     = !out_valid_q || bus.out_ready;
    assign pop          = (state_q == S_DATA) && out_free && !fifo_empty;
    assign load_csum    = (state_q == S_CSUM) && out_free;

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= S_DATA;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DATA:  if (pop && cnt_q == LAST_CNT) state_d = S_CSUM;
            S_CSUM:  if (out_free)                 state_d = S_DATA;
            default: state_d = S_DATA;
        endcase
    end

    // FSM outputs: output register load, running sum and byte count
    always_comb begin
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_is_csum_d = out_is_csum_q;
        pkt_done_d    = 1'b0;
        sum_d         = sum_q;
        cnt_d         = cnt_q;
        if (pop) begin
            out_data_d    = mem_q[rd_ptr_q];
            out_valid_d   = 1'b1;
            out_is_csum_d = 1'b0;
            sum_d         = csum_add(sum_q, mem_q[rd_ptr_q]);
            cnt_d         = cnt_q + CW'(1);
        end else if (load_csum) begin
            out_data_d    = sum_q;
            out_valid_d   = 1'b1;
            out_is_csum_d = 1'b1;
            pkt_done_d    = 1'b1;
            sum_d         = '0;
            cnt_d         = '0;
        end else if (out_free) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_is_csum_q <= 1'b0;
            pkt_done_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_is_csum_q <= out_is_csum_d;
            pkt_done_q    <= pkt_done_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_is_csum = out_is_csum_q;
    assign bus.pkt_done    = pkt_done_q;
endmodule

// File: tb/tb_byte_pack_stage.sv
// Directed bench for byte_pack_stage: table of packets with hand-computed
// checksums, plus stall, streaming, random back-pressure and reset sequences.
module tb_byte_pack_stage;
    localparam int PKT = 4;

    logic clk = 1'b0;
    logic rstn;
    byte_pack_stage_if bus ();

    byte_pack_stage #(.PKT_LEN(PKT), .DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       c;
        int         cyc;
    } beat_t;

    typedef struct {
        logic [7:0] d [PKT];
        logic [7:0] csum;
    } vec_t;

    beat_t      beats[$];
    logic [7:0] src[$];
    int         total = 0;
    int         bad = 0;
    int         rd = 0;
    int         cyc = 0;
    int         pkt_cnt = 0;
    int         stall_seen = 0;
    int         stall_err = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_c = 1'b0;
    bit         prod_done;

    // Output monitor: records accepted beats, pkt_done pulses and stall stability.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                stall_seen <= stall_seen + 1;
                if (!(bus.out_valid && bus.out_data == prev_d && bus.out_is_csum == prev_c))
                    stall_err <= stall_err + 1;
            end
            if (bus.out_valid && bus.out_ready)
                beats.push_back('{bus.out_data, bus.out_is_csum, cyc});
            if (bus.pkt_done) pkt_cnt <= pkt_cnt + 1;
            stall_prev <= bus.out_valid && !bus.out_ready;
            prev_d     <= bus.out_data;
            prev_c     <= bus.out_is_csum;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int k = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beats.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("beats_arrived", 32'(beats.size() >= n), 32'd1);
    endtask

    task automatic expect_beat(input string nm, input logic [7:0] d, input logic c);
        check({nm, "_present"}, 32'(beats.size() > rd), 32'd1);
        if (beats.size() > rd) begin
            check({nm, "_data"}, 32'(beats[rd].d), 32'(d));
            check({nm, "_is_csum"}, 32'(beats[rd].c), 32'(c));
        end
        rd++;
    endtask

    // Reference: src bytes in order with a mod-256 checksum after every PKT bytes.
    task automatic expect_stream(input string nm);
        logic [7:0] s = '0;
        for (int i = 0; i < src.size(); i++) begin
            expect_beat(nm, src[i], 1'b0);
            s = s + src[i];
            if ((i + 1) % PKT == 0) begin
                expect_beat({nm, "_csum"}, s, 1'b1);
                s = '0;
            end
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   acc, lowcnt, idx, guard, pk0, b0;
        logic rdy, rdy6;

        vecs[0].d = '{8'h12, 8'h34, 8'h56, 8'h78}; vecs[0].csum = 8'h14;
        vecs[1].d = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[1].csum = 8'hFC;
        vecs[2].d = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].csum = 8'h00;
        vecs[3].d = '{8'h01, 8'h02, 8'h03, 8'h04}; vecs[3].csum = 8'h0A;
        vecs[4].d = '{8'h80, 8'h80, 8'h01, 8'h7F}; vecs[4].csum = 8'h80;

        rstn         = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        prod_done    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_is_csum", 32'(bus.out_is_csum), 32'd0);
        check("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Table of packets with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pk0 = pkt_cnt;
            for (int j = 0; j < PKT; j++) push(vecs[i].d[j]);
            wait_beats(rd + PKT + 1);
            for (int j = 0; j < PKT; j++) expect_beat("vec", vecs[i].d[j], 1'b0);
            expect_beat("vec_csum", vecs[i].csum, 1'b1);
            check("vec_pkt_done", 32'(pkt_cnt - pk0), 32'd1);
        end
        @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Downstream stalled: output register plus full FIFO absorb five bytes
        bus.out_ready = 1'b0;
        acc  = 0;
        rdy6 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data  = 8'(8'hA0 + i);
            bus.in_valid = 1'b1;
            if (i == 5) rdy6 = bus.in_ready;
            if (bus.in_ready) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("stall_accepted", 32'(acc), 32'd5);
        check("stall_in_ready_6th", 32'(rdy6), 32'd0);
        check("stall_out_data", 32'(bus.out_data), 32'hA0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("stall_out_held", 32'(bus.out_data), 32'hA0);
        pk0 = pkt_cnt;
        bus.out_ready = 1'b1;
        for (int i = 5; i < 8; i++) push(8'(8'hA0 + i));
        wait_beats(rd + 10);
        for (int i = 0; i < 4; i++) expect_beat("stall_drain", 8'(8'hA0 + i), 1'b0);
        expect_beat("stall_csum0", 8'h86, 1'b1);
        for (int i = 4; i < 8; i++) expect_beat("stall_drain", 8'(8'hA0 + i), 1'b0);
        expect_beat("stall_csum1", 8'h96, 1'b1);
        check("stall_pkt_done", 32'(pkt_cnt - pk0), 32'd2);

        // Continuous streaming: in_valid and out_ready both held high
        src.delete();
        for (int i = 0; i < 40; i++) src.push_back(8'(i * 7 + 3));
        b0     = rd;
        idx    = 0;
        lowcnt = 0;
        guard  = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = src[0];
        while (idx < 40 && guard < 500) begin
            rdy = bus.in_ready;
            if (!rdy) lowcnt++;
            @(posedge clk);
            @(negedge clk);
            if (rdy) idx++;
            if (idx < 40) bus.in_data = src[idx];
            guard++;
        end
        bus.in_valid = 1'b0;
        check("stream_in_ready_low", 32'(lowcnt > 0), 32'd1);
        wait_beats(b0 + 50);
        if (beats.size() >= b0 + 50)
            check("stream_throughput", 32'(beats[b0 + 49].cyc - beats[b0].cyc), 32'd49);
        expect_stream("stream");

        // Random back-pressure over 64 bytes
        src.delete();
        for (int i = 0; i < 64; i++) src.push_back(8'($urandom_range(0, 255)));
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    push(src[i]);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_beats(rd + 80);
        expect_stream("rand");
        check("rand_stall_seen", 32'(stall_seen > 0), 32'd1);
        check("rand_stall_stable", 32'(stall_err), 32'd0);

        // Reset in the middle of a packet discards buffered bytes and partial sum
        bus.out_ready = 1'b0;
        push(8'h12);
        push(8'h34);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_is_csum", 32'(bus.out_is_csum), 32'd0);
        check("midrst_pkt_done", 32'(bus.pkt_done), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", 32'(bus.in_ready), 32'd1);
        rd = beats.size();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_beats(rd + 5);
        for (int i = 1; i <= 4; i++) expect_beat("midrst", 8'(i), 1'b0);
        expect_beat("midrst_csum", 8'h0A, 1'b1);
        repeat (10) @(negedge clk);
        check("midrst_no_extra", 32'(beats.size()), 32'(rd));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
